// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: serializes icache reads and dcache reads/writes onto a
// single RAM port. The dcache has priority. A starvation counter forces an
// icache grant after STARVE_MAX consecutive dcache completions while the
// icache is waiting.
// Optional build macro ARB_PERF_EN adds free-running completion counters
// (icnt, dcnt).
// caches_pkg holds the RAM handshake type shared with the RAM model.

package caches_pkg;
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;
endpackage

// Request/wait handshake (both requesters):
//   A requester raises its request with address and store data, and holds
//   them stable while its wait is 1. The single cycle with wait=0 is the
//   completion cycle; load data is valid only in that cycle. In the next
//   cycle the requester drops the request, unless it wants another transfer,
//   in which case the held request is arbitrated again. Dropping every
//   request line before completion aborts the transfer with no wait pulse.
module cache_mem_arbiter
  import caches_pkg::*;
#(
  // Legal range 1..15 (the counter is 4 bits wide).
  parameter int unsigned  STARVE_MAX = 4,
  parameter logic [31:0]  ERR_WORD   = 32'hBAD1BAD1
) (
  input  logic        CLK,
  input  logic        RST,
  // icache side
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  // dcache side
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  // RAM side
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  ramstate_t   ramstate,
  output logic        err,
`ifdef ARB_PERF_EN
  output logic [31:0] icnt,
  output logic [31:0] dcnt,
`endif
  // debug visibility of the FSM and the starvation counter
  output logic [1:0]  state_dbg,
  output logic [3:0]  starve_cnt_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t     state;
  state_t     next_state;
  logic [3:0] starve_cnt;
  logic       d_req;
  logic       ram_done;
  logic       i_done;
  logic       d_done;
  logic       xfer_err;

  assign d_req    = dREN | dWEN;
  assign ram_done = (ramstate == ACCESS) || (ramstate == ERROR);

  assign state_dbg      = state;
  assign starve_cnt_dbg = starve_cnt;

  // Grant steering, RAM strobes, completion detection and next-state choice.
  // RST forces the idle output values in the same cycle so a reset that
  // lands on a completing transfer never produces a wait=0 pulse.
  always_comb begin
    next_state = state;
    iwait      = 1'b1;
    dwait      = 1'b1;
    iload      = '0;
    dload      = '0;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;
    i_done     = 1'b0;
    d_done     = 1'b0;
    xfer_err   = 1'b0;
    if (!RST) begin
      case (state)
        IDLE: begin
          // The icache wins only once it has watched STARVE_MAX dcache
          // completions go by while waiting.
          if (d_req && !(iREN && (starve_cnt == STARVE_LIM))) begin
            next_state = DGNT;
          end else if (iREN) begin
            next_state = IGNT;
          end
        end
        IGNT: begin
          if (!iREN) begin
            // Abort: strobes already low, no completion.
            next_state = IDLE;
          end else begin
            ramREN  = 1'b1;
            ramaddr = iaddr;
            if (ram_done) begin
              iwait      = 1'b0;
              i_done     = 1'b1;
              next_state = IDLE;
              if (ramstate == ERROR) begin
                iload    = ERR_WORD;
                xfer_err = 1'b1;
              end else begin
                iload = ramload;
              end
            end
          end
        end
        DGNT: begin
          if (!d_req) begin
            next_state = IDLE;
          end else begin
            ramaddr  = daddr;
            ramstore = dstore;
            // A write takes precedence when both strobes are raised.
            ramWEN   = dWEN;
            ramREN   = dREN & ~dWEN;
            if (ram_done) begin
              dwait      = 1'b0;
              d_done     = 1'b1;
              next_state = IDLE;
              if (ramstate == ERROR) begin
                dload    = ERR_WORD;
                xfer_err = 1'b1;
              end else begin
                dload = ramload;
              end
            end
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  // State register, sticky error flag and the starvation counter.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      starve_cnt <= '0;
      err        <= 1'b0;
    end else begin
      state <= next_state;
      if (xfer_err) begin
        err <= 1'b1;
      end
      if (i_done || ((state == IDLE) && !iREN)) begin
        starve_cnt <= '0;
      end else if (d_done && iREN && (starve_cnt < STARVE_LIM)) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

`ifdef ARB_PERF_EN
  // Completion counters; aborts never assert i_done/d_done so they do not count.
  always_ff @(posedge CLK) begin
    if (RST) begin
      icnt <= '0;
      dcnt <= '0;
    end else begin
      if (i_done) begin
        icnt <= icnt + 32'd1;
      end
      if (d_done) begin
        dcnt <= dcnt + 32'd1;
      end
    end
  end
`endif

endmodule
